// File: rtl/esm_random_issue_selector.sv
// Random issue selector: live candidate list, sequential compaction scan and LFSR draw.
// ESM_CLEAR_ON_GRANT_EN: clear the granted candidate on handshake (sampling without replacement).
module esm_random_issue_selector #(
   parameter int BS = 16,
   parameter int LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
   localparam int IW = $clog2(BS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ins_valid,
   input  logic [IW-1:0] ins_index,
   input  logic          sel_req,
   output logic          sel_valid,
   output logic [IW-1:0] sel_index,
   input  logic          sel_ready,
   output logic          busy,
   output logic [IW:0]   count,
   output logic          empty,
   output logic          full
);

   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

   typedef enum logic [1:0] {IDLE, BUILD, DRAW, PRESENT} state_t;

   state_t        state_reg, state_next;
   logic [BS-1:0] cand_reg;
   logic [BS-1:0] snap_reg, snap_next;
   logic [IW-1:0] ptr_reg, ptr_next;
   logic [IW:0]   mcnt_reg, mcnt_next;
   logic          sel_valid_reg, sel_valid_next;
   logic [IW-1:0] sel_index_reg, sel_index_next;
   logic [IW:0]   count_reg, count_next;
   logic          empty_reg, full_reg;
   logic [LFSR_W-1:0] lfsr_reg;
   logic [IW-1:0] map_mem [BS];
   logic          map_we;
   logic          grant, clr, ins_new, clr_eff;
   logic [IW-1:0] draw_k;

   assign grant   = sel_valid_reg && sel_ready;
   assign ins_new = ins_valid && !cand_reg[ins_index];
`ifdef ESM_CLEAR_ON_GRANT_EN
   assign clr     = grant;
   // A same-index insert on the grant edge keeps the bit, so nothing is removed.
   assign clr_eff = grant && cand_reg[sel_index_reg] && !(ins_valid && ins_index == sel_index_reg);
`else
   assign clr     = 1'b0;
   assign clr_eff = 1'b0;
`endif
   assign count_next = count_reg + (IW+1)'(ins_new) - (IW+1)'(clr_eff);

   genvar gi;
   generate
      for (gi = 0; gi < BS; gi++) begin : g_cand
         always_ff @(posedge clk) begin
            if (!rst_n)
               cand_reg[gi] <= 1'b0;
            else if (ins_valid && ins_index == IW'(gi))
               cand_reg[gi] <= 1'b1;
            else if (clr && sel_index_reg == IW'(gi))
               cand_reg[gi] <= 1'b0;
         end
      end
   endgenerate

   // Fibonacci LFSR, x^16+x^14+x^13+x^11+1
   always_ff @(posedge clk) begin
      if (!rst_n)
         lfsr_reg <= SEED_EFF;
      else
         lfsr_reg <= {lfsr_reg[LFSR_W-2:0],
                      lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
         empty_reg <= 1'b1;
         full_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == (IW+1)'(BS));
      end
   end

   always_ff @(posedge clk) begin
      if (map_we)
         map_mem[mcnt_reg[IW-1:0]] <= ptr_reg;
   end

   assign draw_k = IW'(lfsr_reg % LFSR_W'(mcnt_reg));

   always_comb begin
      state_next     = state_reg;
      snap_next      = snap_reg;
      ptr_next       = ptr_reg;
      mcnt_next      = mcnt_reg;
      sel_valid_next = sel_valid_reg;
      sel_index_next = sel_index_reg;
      map_we         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sel_req && count_reg != '0) begin
               snap_next  = cand_reg;
               ptr_next   = '0;
               mcnt_next  = '0;
               state_next = BUILD;
            end
         end
         BUILD: begin
            if (snap_reg[ptr_reg]) begin
               map_we    = 1'b1;
               mcnt_next = mcnt_reg + 1'b1;
            end
            if (ptr_reg == IW'(BS-1))
               state_next = DRAW;
            else
               ptr_next = ptr_reg + 1'b1;
         end
         DRAW: begin
            sel_index_next = map_mem[draw_k];
            sel_valid_next = 1'b1;
            state_next     = PRESENT;
         end
         PRESENT: begin
            if (grant) begin
               sel_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         snap_reg      <= '0;
         ptr_reg       <= '0;
         mcnt_reg      <= '0;
         sel_valid_reg <= 1'b0;
         sel_index_reg <= '0;
      end else begin
         state_reg     <= state_next;
         snap_reg      <= snap_next;
         ptr_reg       <= ptr_next;
         mcnt_reg      <= mcnt_next;
         sel_valid_reg <= sel_valid_next;
         sel_index_reg <= sel_index_next;
      end
   end

   assign sel_valid = sel_valid_reg;
   assign sel_index = sel_index_reg;
   assign busy      = (state_reg != IDLE);
   assign count     = count_reg;
   assign empty     = empty_reg;
   assign full      = full_reg;

endmodule

// File: tb/tb_esm_random_issue_selector.sv
// Directed bench for esm_random_issue_selector with a reference LFSR for draw prediction.
module tb_esm_random_issue_selector;

   localparam int BS = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ins_valid = 1'b0;
   logic [IW-1:0] ins_index = '0;
   logic          sel_req = 1'b0;
   logic          sel_ready = 1'b0;
   logic          sel_valid;
   logic [IW-1:0] sel_index;
   logic          busy;
   logic [IW:0]   count;
   logic          empty;
   logic          full;

   int vectors = 0;
   int errors  = 0;

   logic [15:0] m_lfsr = 16'h0;
   logic [15:0] m_prev = 16'h0;

   esm_random_issue_selector #(.BS(BS), .LFSR_W(16), .SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_index(ins_index),
      .sel_req(sel_req), .sel_valid(sel_valid), .sel_index(sel_index),
      .sel_ready(sel_ready), .busy(busy), .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // Reference LFSR; m_prev holds the value that was live before the most recent edge.
   always @(posedge clk) begin
      m_prev <= m_lfsr;
      if (!rst_n)
         m_lfsr <= 16'hACE1;
      else
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else
         $display("  ok %s = %0d", tag, got);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic insert(input int idx);
      ins_valid = 1'b1;
      ins_index = IW'(idx);
      tick();
      ins_valid = 1'b0;
   endtask

   // Request a draw; returns edges counted from the request edge (inclusive) and the LFSR used.
   task automatic draw(output int lat, output logic [15:0] r);
      sel_req = 1'b1;
      lat = 0;
      r = '0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         sel_req = 1'b0;
         lat = n;
         if (sel_valid) begin
            r = m_prev;
            break;
         end
      end
   endtask

   task automatic handshake();
      sel_ready = 1'b1;
      tick();
      sel_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [15:0] r;
      int list[$];
      int exp_idx;
      int pos;
      logic flag;
      logic [IW-1:0] held;

      // Reset with an insert pending
      rst_n = 1'b0;
      ins_valid = 1'b1;
      ins_index = 4'd4;
      tick();
      tick();
      ins_valid = 1'b0;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_sel_valid", sel_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_lfsr", dut.lfsr_reg, 16'hACE1);
      rst_n = 1'b1;

      // Insert with a duplicate, then draw
      insert(3); insert(7); insert(12); insert(7);
      check("ins_count", count, 3);
      check("ins_full", full, 0);
      draw(lat, r);
      list = '{3, 7, 12};
      check("draw1_latency", lat, 18);
      check("draw1_busy", busy, 1);
      check("draw1_index", sel_index, list[r % 3]);
      handshake();
      check("draw1_done_valid", sel_valid, 0);
      check("draw1_done_busy", busy, 0);
`ifdef ESM_CLEAR_ON_GRANT_EN
      check("draw1_done_count", count, 2);
`else
      check("draw1_done_count", count, 3);
`endif

      // Request with nothing to pick
      do_reset();
      sel_req = 1'b1;
      tick();
      sel_req = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (busy || sel_valid) flag = 1'b1;
         tick();
      end
      check("empty_req_quiet", flag, 0);
      insert(5);
      draw(lat, r);
      check("single_latency", lat, 18);
      check("single_index", sel_index, 5);
      handshake();

      // Backpressure and an insert during BUILD
      do_reset();
      insert(0); insert(15);
      sel_req = 1'b1;
      tick();
      sel_req = 1'b0;
      tick();
      insert(9);
      lat = 0;
      r = '0;
      for (int n = 0; n < 40; n++) begin
         if (sel_valid) begin
            r = m_prev;
            lat = 1;
            break;
         end
         tick();
      end
      check("bp_valid_seen", lat, 1);
      list = '{0, 15};
      exp_idx = list[r % 2];
      check("bp_index", sel_index, exp_idx);
      held = sel_index;
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!sel_valid || sel_index != held) flag = 1'b1;
      end
      check("bp_stable", flag, 0);
      check("bp_count", count, 3);
      handshake();
      check("bp_release", sel_valid, 0);

`ifdef ESM_CLEAR_ON_GRANT_EN
      // Sampling without replacement drains every entry exactly once
      do_reset();
      for (int i = 0; i < BS; i++) insert(i);
      check("fill_full", full, 1);
      list = {};
      for (int i = 0; i < BS; i++) list.push_back(i);
      for (int d = 0; d < BS; d++) begin
         draw(lat, r);
         pos = r % list.size();
         check($sformatf("wo_idx%0d", d), sel_index, list[pos]);
         list.delete(pos);
         handshake();
         check($sformatf("wo_cnt%0d", d), count, list.size());
      end
      check("wo_empty", empty, 1);
`else
      // Fill every entry; with the full set the compacted map is the identity
      do_reset();
      for (int i = 0; i < BS; i++) insert(i);
      check("fill_full", full, 1);
      check("fill_count", count, 16);
      draw(lat, r);
      check("full_latency", lat, 18);
      check("full_index", sel_index, r % 16);
      handshake();
      check("full_after", count, 16);
`endif

      // Same-index insert on the grant edge leaves count unchanged
      do_reset();
      insert(2); insert(6);
      draw(lat, r);
      list = '{2, 6};
      check("same_idx", sel_index, list[r % 2]);
      ins_valid = 1'b1;
      ins_index = sel_index;
      sel_ready = 1'b1;
      tick();
      ins_valid = 1'b0;
      sel_ready = 1'b0;
      check("same_idx_count", count, 2);

      // Reset in the middle of BUILD
      do_reset();
      insert(1);
      sel_req = 1'b1;
      tick();
      sel_req = 1'b0;
      repeat (4) tick();
      check("midb_busy_pre", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midb_busy", busy, 0);
      check("midb_count", count, 0);
      check("midb_valid", sel_valid, 0);
      flag = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (sel_valid || busy) flag = 1'b1;
         tick();
      end
      check("midb_quiet", flag, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
